hls_deadlock_report_unit: RTL
=============================

HLS_DEADLOCK_REPORT_UNIT -- requirements
Module: hls_deadlock_report_unit

Interface
REQ-001 Parameter PROC_NUM, default 4: number of dataflow processes monitored.
REQ-002 Parameter ID_W, default 2: width of a process index, equal to clog2(PROC_NUM).
REQ-003 Parameter TO_W, default 8: width of the trace-timeout counter.
REQ-004 clock  input  1  sole clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-low reset; sampled only on the rising clock edge.
REQ-006 dl_in_vec  input  PROC_NUM  bit i is the combinational deadlock-detect output of process i.
REQ-007 token_seen_vec  input  PROC_NUM  bit i is high when the report token arrives at process i this cycle (OR of that process's token inputs).
REQ-008 rpt_ack  input  1  consumer accepts the report.
REQ-009 origin_vec  output  PROC_NUM  one-hot origin strobe to the selected process's detect unit.
REQ-010 token_clear  output  1  combinational; kills token forwarding in the cycle the token returns to the origin.
REQ-011 dl_detect  output  1  sticky global deadlock flag.
REQ-012 rpt_vld  output  1  report valid.
REQ-013 rpt_origin_id  output  ID_W  index of the origin process.
REQ-014 rpt_cycle_mask  output  PROC_NUM  processes visited by the token, origin included.
REQ-015 rpt_hops  output  ID_W+1  population count of rpt_cycle_mask.
REQ-016 rpt_timeout  output  1  report was closed by timeout, not by token return.

Function
REQ-017 The FSM SHALL have the states IDLE, ORIGIN, TRACE, REPORT and DONE, held in one state register.
REQ-018 In IDLE with |dl_in_vec=1, the block SHALL latch the lowest set index into origin_id, set dl_detect, and enter ORIGIN on the next edge; the lowest index wins on simultaneous detects.
REQ-019 In ORIGIN, origin_vec SHALL equal onehot(origin_id) for exactly one cycle; mask SHALL load onehot(origin_id); the FSM SHALL then enter TRACE.
REQ-020 Outside ORIGIN, origin_vec SHALL be all-zero.
REQ-021 In TRACE, mask SHALL OR in token_seen_vec every cycle.
REQ-022 token_clear SHALL equal (state==TRACE) & token_seen_vec[origin_id], with zero latency; when it is high, the FSM SHALL enter REPORT on the next edge.
REQ-023 Token arrival at the origin during the ORIGIN cycle SHALL be ignored.
REQ-024 In REPORT, rpt_vld SHALL be 1 and all rpt_* outputs SHALL hold stable until the cycle rpt_ack=1, then the FSM SHALL enter DONE.
REQ-025 rpt_ack outside REPORT SHALL be ignored.
REQ-026 rpt_hops SHALL be computed from the final mask, saturating-free (maximum value PROC_NUM).
REQ-027 DONE SHALL be absorbing until reset; dl_in_vec and token_seen_vec SHALL be ignored in DONE, and dl_detect SHALL stay 1.
REQ-028 dl_in_vec changes after leaving IDLE SHALL NOT alter origin_id.

Reset
REQ-029 On reset=0 at a rising edge, the block SHALL clear all state: FSM=IDLE, dl_detect=0, origin_vec=0, rpt_vld=0, rpt_origin_id=0, rpt_cycle_mask=0, rpt_hops=0, rpt_timeout=0, timeout counter=0.
REQ-030 Reset asserted in any state, including mid-TRACE or mid-REPORT, SHALL abort that operation with no report.
REQ-031 token_clear SHALL be 0 during and after reset, because the FSM is in IDLE.

Configuration
REQ-032 With HLS_DEADLOCK_TRACE_TIMEOUT_EN defined, a TO_W-bit counter SHALL clear on entry to TRACE and increment each TRACE cycle.
REQ-033 With HLS_DEADLOCK_TRACE_TIMEOUT_EN defined, if the counter reaches 2^TO_W-1 without token return, token_clear SHALL pulse in that cycle, rpt_timeout SHALL set, and the FSM SHALL enter REPORT.
REQ-034 With HLS_DEADLOCK_TRACE_TIMEOUT_EN defined, if token return and timeout coincide, the return SHALL win and rpt_timeout SHALL be 0.
REQ-035 Without HLS_DEADLOCK_TRACE_TIMEOUT_EN, no counter SHALL exist, rpt_timeout SHALL be tied to 0, and TRACE SHALL wait indefinitely.

Verification (PROC_NUM=4)
REQ-036 dl_in_vec=4'b0100 in IDLE -> dl_detect=1 next cycle; origin_vec=4'b0100 for one cycle; no other origin pulse.
REQ-037 Origin 2; token_seen_vec=4'b1000, then 4'b0001, then 4'b0100 -> token_clear=1 only in the third cycle; rpt_cycle_mask=4'b1101, rpt_hops=3, rpt_origin_id=2, rpt_timeout=0.
REQ-038 Simultaneous dl_in_vec=4'b1010 -> rpt_origin_id=1; a later dl_in_vec=4'b0001 does not change it.
REQ-039 rpt_vld held 5 cycles with rpt_ack=0, then rpt_ack=1 -> outputs stable throughout; DONE entered; a new dl_in_vec is ignored and dl_detect stays 1.
REQ-040 Reset=0 mid-TRACE -> next cycle all outputs zero and FSM in IDLE; a fresh detect restarts cleanly.
REQ-041 Macro defined, TO_W=4, no token return -> token_clear and rpt_timeout=1 after 15 TRACE cycles; rpt_cycle_mask=onehot(origin).

Source files
------------

// File: rtl/hls_deadlock_report_unit.sv
// Deadlock report unit: picks an origin process, traces the report token around the cycle and
// presents the visited mask. Optional trace timeout guarded by HLS_DEADLOCK_TRACE_TIMEOUT_EN.
module hls_deadlock_report_unit #(
    parameter int PROC_NUM = 4,
    parameter int ID_W     = 2,
    parameter int TO_W     = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [PROC_NUM-1:0] dl_in_vec,
    input  logic [PROC_NUM-1:0] token_seen_vec,
    input  logic                rpt_ack,
    output logic [PROC_NUM-1:0] origin_vec,
    output logic                token_clear,
    output logic                dl_detect,
    output logic                rpt_vld,
    output logic [ID_W-1:0]     rpt_origin_id,
    output logic [PROC_NUM-1:0] rpt_cycle_mask,
    output logic [ID_W:0]       rpt_hops,
    output logic                rpt_timeout
);

    typedef enum logic [2:0] {IDLE, ORIGIN, TRACE, REPORT, DONE} state_t;

    state_t              state;
    logic [ID_W-1:0]     origin_id;
    logic [PROC_NUM-1:0] mask;
    logic                tok_ret;
    logic                to_hit;

    function automatic logic [ID_W-1:0] lowest_idx(input logic [PROC_NUM-1:0] v);
        logic [ID_W-1:0] idx;
        idx = '0;
        for (int i = PROC_NUM - 1; i >= 0; i--)
            if (v[i]) idx = ID_W'(i);
        return idx;
    endfunction

    function automatic logic [PROC_NUM-1:0] onehot(input logic [ID_W-1:0] id);
        logic [PROC_NUM-1:0] v;
        v = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    function automatic logic [ID_W:0] popcount(input logic [PROC_NUM-1:0] v);
        logic [ID_W:0] n;
        n = '0;
        for (int i = 0; i < PROC_NUM; i++)
            n = n + (ID_W+1)'(v[i]);
        return n;
    endfunction

    assign tok_ret     = (state == TRACE) && token_seen_vec[origin_id];
    assign token_clear = tok_ret || to_hit;

    assign rpt_origin_id  = origin_id;
    assign rpt_cycle_mask = mask;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            origin_id  <= '0;
            dl_detect  <= 1'b0;
            origin_vec <= '0;
            rpt_vld    <= 1'b0;
            mask       <= '0;
            rpt_hops   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|dl_in_vec) begin
                        origin_id  <= lowest_idx(dl_in_vec);
                        origin_vec <= onehot(lowest_idx(dl_in_vec));
                        dl_detect  <= 1'b1;
                        state      <= ORIGIN;
                    end
                end
                // Token seen at the origin here is the strobe's own echo, so the mask starts clean.
                ORIGIN: begin
                    origin_vec <= '0;
                    mask       <= onehot(origin_id);
                    rpt_hops   <= popcount(onehot(origin_id));
                    state      <= TRACE;
                end
                TRACE: begin
                    mask     <= mask | token_seen_vec;
                    rpt_hops <= popcount(mask | token_seen_vec);
                    if (token_clear) begin
                        rpt_vld <= 1'b1;
                        state   <= REPORT;
                    end
                end
                REPORT: begin
                    if (rpt_ack) begin
                        rpt_vld <= 1'b0;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef HLS_DEADLOCK_TRACE_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt;

    assign to_hit = (state == TRACE) && (to_cnt == '1);

    // Token return outranks a coincident timeout, so the flag only sets on a bare expiry.
    always_ff @(posedge clock) begin
        if (!reset) begin
            to_cnt      <= '0;
            rpt_timeout <= 1'b0;
        end else begin
            if (state == ORIGIN)
                to_cnt <= '0;
            else if (state == TRACE)
                to_cnt <= to_cnt + 1'b1;
            if (to_hit && !tok_ret)
                rpt_timeout <= 1'b1;
        end
    end
`else
    assign to_hit      = 1'b0;
    assign rpt_timeout = 1'b0;
`endif

endmodule
